// File: rtl/vr_sink_gen.sv
// vr_sink_gen: programmable valid/ready sink with fixed/random/always/stall backpressure and beat counters.
// Optional sequence checker enabled by defining VR_SINK_SEQ_CHECK_EN.
module vr_sink_gen #(
  parameter int          DATA_WIDTH  = 8,
  parameter int          DELAY_BITS  = 3,
  parameter int          COUNT_WIDTH = 16,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DELAY_BITS-1:0]  delay,
  input  logic [1:0]             mode,
  input  logic                   vr_bus_valid,
  input  logic [DATA_WIDTH-1:0]  vr_bus_data,
  output logic                   vr_bus_ready,
  output logic [DATA_WIDTH-1:0]  last_data,
  output logic [COUNT_WIDTH-1:0] rx_count,
  output logic [COUNT_WIDTH-1:0] err_count,
  output logic                   err_pulse
);
  typedef enum logic {PROCESS_DELAY, WAIT_HANDSHAKE} state_t;
  localparam logic [DELAY_BITS:0] ONE = 1;
  state_t state;
  logic [DELAY_BITS-1:0] delay_count, target, t_new, t_eff, lfsr_low;
  logic [15:0] lfsr, lfsr_nx;
  logic armed, hs, done;
  assign hs       = vr_bus_valid && vr_bus_ready;
  assign lfsr_nx  = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign lfsr_low = lfsr[DELAY_BITS-1:0];
  assign t_new    = (mode == 2'b01 && lfsr_low < delay) ? lfsr_low : delay;
  // armed is clear when no target has been sampled yet for this delay phase
  assign t_eff    = armed ? target : t_new;
  assign done     = t_eff == '0 || ({1'b0, delay_count} + ONE) == {1'b0, t_eff};
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= PROCESS_DELAY;
      delay_count  <= '0;
      target       <= '0;
      armed        <= 1'b0;
      lfsr         <= LFSR_SEED;
      vr_bus_ready <= 1'b0;
      last_data    <= '0;
      rx_count     <= '0;
    end else begin
      lfsr <= lfsr_nx;
      if (hs) begin
        last_data <= vr_bus_data;
        if (!(&rx_count)) rx_count <= rx_count + COUNT_WIDTH'(1);
      end
      if (mode == 2'b10) begin
        vr_bus_ready <= 1'b1;
        state        <= WAIT_HANDSHAKE;
      end else if (mode == 2'b11) begin
        vr_bus_ready <= 1'b0;
        state        <= PROCESS_DELAY;
        delay_count  <= '0;
        armed        <= 1'b0;
      end else if (state == PROCESS_DELAY) begin
        armed       <= 1'b1;
        target      <= t_eff;
        delay_count <= delay_count + DELAY_BITS'(1);
        if (done) begin
          vr_bus_ready <= 1'b1;
          state        <= WAIT_HANDSHAKE;
        end
      end else if (hs) begin
        target <= t_new;
        armed  <= 1'b1;
        if (t_new != '0) begin
          vr_bus_ready <= 1'b0;
          delay_count  <= '0;
          state        <= PROCESS_DELAY;
        end
      end
    end
  end
`ifdef VR_SINK_SEQ_CHECK_EN
  logic                  seeded;
  logic [DATA_WIDTH-1:0] exp_data;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seeded    <= 1'b0;
      exp_data  <= '0;
      err_count <= '0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      if (hs) begin
        seeded   <= 1'b1;
        exp_data <= vr_bus_data + DATA_WIDTH'(1);
        if (seeded && vr_bus_data != exp_data) begin
          err_pulse <= 1'b1;
          if (!(&err_count)) err_count <= err_count + COUNT_WIDTH'(1);
        end
      end
    end
  end
`else
  assign err_count = '0;
  assign err_pulse = 1'b0;
`endif
endmodule
